// File: rtl/fft_pkg.sv
// Shared FFT definitions: output-streamer FSM encoding and FP4 complex field layout.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } fft_state_e;

  localparam int RE_MSB = 7;
  localparam int RE_LSB = 4;
  localparam int IM_MSB = 3;
  localparam int IM_LSB = 0;

  function automatic logic [7:0] fp4_cplx(input logic [3:0] re, input logic [3:0] im);
    logic [7:0] v;
    v                = 8'd0;
    v[RE_MSB:RE_LSB] = re;
    v[IM_MSB:IM_LSB] = im;
    return v;
  endfunction

endpackage

// File: rtl/fft_out_skid.sv
// Two-entry FIFO with registered head; accepts a push on a full cycle when the head pops.
module fft_out_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         valid,
  output logic         full,
  output logic [W-1:0] dout
);

  logic [W-1:0] head_r, tail_r, head_nxt, tail_nxt;
  logic [1:0]   cnt_r, cnt_nxt;
  logic         pop_s;

  assign pop_s = pop & valid;
  assign dout  = head_r;

  // Next occupancy and entry contents
  always_comb begin
    cnt_nxt  = cnt_r;
    head_nxt = head_r;
    tail_nxt = tail_r;
    case (cnt_r)
      2'd0: begin
        if (push) begin
          head_nxt = din;
          cnt_nxt  = 2'd1;
        end else begin
          cnt_nxt = 2'd0;
        end
      end
      2'd1: begin
        if (push && pop_s) begin
          head_nxt = din;
        end else if (push) begin
          tail_nxt = din;
          cnt_nxt  = 2'd2;
        end else if (pop_s) begin
          cnt_nxt = 2'd0;
        end else begin
          cnt_nxt = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_nxt = tail_r;
          if (push) begin
            tail_nxt = din;
          end else begin
            cnt_nxt = 2'd1;
          end
        end else begin
          cnt_nxt = 2'd2;
        end
      end
      default: cnt_nxt = 2'd0;
    endcase
  end

  // Storage and registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= 2'd0;
      valid  <= 1'b0;
      full   <= 1'b0;
    end else begin
      head_r <= head_nxt;
      tail_r <= tail_nxt;
      cnt_r  <= cnt_nxt;
      valid  <= (cnt_nxt != 2'd0);
      full   <= (cnt_nxt == 2'd2);
    end
  end

endmodule

// File: rtl/fft_out_streamer.sv
// Streams a finished FFT frame out of the core as a valid/ready sample stream.
// Optional macro FFT_OUT_FRAME_CNT_EN adds an 8-bit wrapping frame counter output.
module fft_out_streamer
  import fft_pkg::*;
#(
  parameter int MAX_N      = 32,
  parameter int ADDR_WIDTH = $clog2(MAX_N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fft_done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [7:0]            rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic [ADDR_WIDTH-1:0] m_index,
  output logic                  m_last,
  output logic                  busy,
  output logic                  frame_done,
`ifdef FFT_OUT_FRAME_CNT_EN
  output logic [7:0]            frame_cnt,
`endif
  output logic                  overrun
);

  localparam int                    PW       = 8 + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(MAX_N - 1);

  fft_state_e            state_r, state_nxt;
  logic                  done_q, armed_r, start_s;
  logic [ADDR_WIDTH-1:0] rd_cnt_r, rd_cnt_nxt;
  logic                  push_s, pop_s, last_rd_s, frame_end_s;
  logic                  fifo_full_s, fifo_valid_s;
  logic [PW-1:0]         din_s, head_s;

  // armed_r blocks a level still high from before reset from looking like a new edge
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      done_q  <= fft_done;
      armed_r <= armed_r | ~fft_done;
    end
  end

  assign start_s = fft_done & ~done_q & armed_r;
  assign pop_s   = fifo_valid_s & m_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt = ST_STREAM;
        else         state_nxt = ST_IDLE;
      end
      ST_STREAM: begin
        if (push_s && last_rd_s) state_nxt = ST_DRAIN;
        else                     state_nxt = ST_STREAM;
      end
      ST_DRAIN: begin
        if (frame_end_s) state_nxt = ST_IDLE;
        else             state_nxt = ST_DRAIN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: read/push control and the bin payload
  always_comb begin
    push_s      = 1'b0;
    frame_end_s = 1'b0;
    last_rd_s   = (rd_cnt_r == LAST_BIN);
    rd_cnt_nxt  = rd_cnt_r;
    din_s       = {fp4_cplx(rd_data[RE_MSB:RE_LSB], rd_data[IM_MSB:IM_LSB]), rd_cnt_r, last_rd_s};
    case (state_r)
      ST_STREAM: begin
        push_s = ~fifo_full_s | pop_s;
        if (push_s) begin
          rd_cnt_nxt = last_rd_s ? '0 : rd_cnt_r + ADDR_WIDTH'(1);
        end else begin
          rd_cnt_nxt = rd_cnt_r;
        end
      end
      ST_DRAIN: begin
        frame_end_s = pop_s & head_s[0];
      end
      default: begin
        push_s      = 1'b0;
        frame_end_s = 1'b0;
      end
    endcase
  end

  // rd_cnt rests at zero outside STREAM, so it doubles as the read address
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rd_cnt_r   <= rd_cnt_nxt;
      busy       <= (state_nxt != ST_IDLE);
      frame_done <= frame_end_s;
      overrun    <= overrun | (start_s & (state_r != ST_IDLE));
    end
  end

  assign rd_addr = rd_cnt_r;

`ifdef FFT_OUT_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'd0;
    end else if (frame_end_s) begin
      frame_cnt <= frame_cnt + 8'd1;
    end else begin
      frame_cnt <= frame_cnt;
    end
  end
`endif

  fft_out_skid #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .din   (din_s),
    .pop   (m_ready),
    .valid (fifo_valid_s),
    .full  (fifo_full_s),
    .dout  (head_s)
  );

  assign m_valid = fifo_valid_s;
  assign m_data  = head_s[PW-1 -: 8];
  assign m_index = head_s[ADDR_WIDTH:1];
  assign m_last  = head_s[0];

endmodule

// File: tb/tb_fft_out_streamer.sv
// Directed scoreboard bench for fft_out_streamer; frame counter test runs when FFT_OUT_FRAME_CNT_EN is defined.
module tb_fft_out_streamer;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst, fft_done, m_ready;
  logic [AW-1:0] rd_addr, m_index;
  logic [7:0]    rd_data, m_data;
  logic          m_valid, m_last, busy, frame_done, overrun;
`ifdef FFT_OUT_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  logic [7:0]  mem [N];
  logic [13:0] exp_q [$];
  logic        fd_exp = 1'b0;
  logic        prev_stall = 1'b0;
  logic [14:0] prev_s = 15'd0;
  int          total = 0;
  int          bad = 0;
  int          vcnt = 0;
  int          dcyc = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  fft_out_streamer #(.MAX_N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .fft_done   (fft_done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_index    (m_index),
    .m_last     (m_last),
    .busy       (busy),
    .frame_done (frame_done),
`ifdef FFT_OUT_FRAME_CNT_EN
    .frame_cnt  (frame_cnt),
`endif
    .overrun    (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_exp();
    for (int i = 0; i < N; i++) exp_q.push_back({mem[i], AW'(i), (i == N - 1)});
  endtask

  // Called at a negedge: set m_ready, check outputs, advance one clock to the next negedge.
  task automatic tick(input logic rdy);
    logic [13:0] e;
    m_ready = rdy;
    chk("frame_done", 32'(frame_done), 32'(fd_exp));
    fd_exp = 1'b0;
    if (prev_stall) chk("hold", 32'({m_valid, m_data, m_index, m_last}), 32'(prev_s));
    if (m_valid && rdy) begin
      if (exp_q.size() == 0) begin
        chk("extra_sample", 32'(m_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sample", 32'({m_data, m_index, m_last}), 32'(e));
        fd_exp = e[0];
      end
    end
    prev_stall = m_valid && !rdy;
    prev_s     = {m_valid, m_data, m_index, m_last};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int mode);
    int n = 0;
    vcnt = 0;
    while (!frame_done && n < 400) begin
      if (m_valid) vcnt++;
      tick(mode == 0 ? 1'b1 : logic'(n[0]));
      n++;
    end
    dcyc = n;
    chk("frame_end", 32'({frame_done, busy}), 32'd2);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(m_valid && m_index == AW'(idx)) && n < 100) begin
      tick(1'b1);
      n++;
    end
    chk("reach_bin", 32'({m_valid, m_index}), 32'({1'b1, AW'(idx)}));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    fd_exp = 1'b0;
    prev_stall = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    fft_done = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = 8'h20;

    do_reset();
    chk("reset_out", 32'({m_valid, m_data, m_index, m_last, busy, frame_done, overrun, rd_addr}), 32'd0);
    tick(1'b1);

    // Impulse frame, ready held high: latency, 32 consecutive samples, frame_done timing
    load_exp();
    fft_done = 1'b1;
    tick(1'b1);
    chk("latency_1", 32'(m_valid), 32'd0);
    tick(1'b1);
    chk("latency_2", 32'({m_valid, m_index}), 32'({1'b1, 5'd0}));
    drain(0);
    chk("consec_valid", 32'(vcnt), 32'(N));
    chk("frame_cycles", 32'(dcyc), 32'(N));
    repeat (4) begin
      tick(1'b1);
      chk("no_retrigger", 32'({m_valid, busy}), 32'd0);
    end
    fft_done = 1'b0;
    tick(1'b1);

    // Ramp data, alternating ready; then restart on the first idle cycle
    for (int i = 0; i < N; i++) mem[i] = 8'(i * 37 + 11);
    load_exp();
    fft_done = 1'b1;
    tick(1'b0);
    fft_done = 1'b0;
    drain(1);
    load_exp();
    fft_done = 1'b1;
    tick(1'b1);
    chk("restart_busy", 32'(busy), 32'd1);
    fft_done = 1'b0;
    drain(0);

    // Ten-cycle stall with bin 5 at the head
    load_exp();
    fft_done = 1'b1;
    tick(1'b1);
    fft_done = 1'b0;
    wait_idx(5);
    repeat (10) tick(1'b0);
    chk("stall_addr", 32'(rd_addr), 32'd7);
    chk("stall_head", 32'({m_valid, m_index}), 32'({1'b1, 5'd5}));
    drain(0);

    // Second fft_done edge at bin 12: overrun sticks, frame completes unchanged
    load_exp();
    fft_done = 1'b1;
    tick(1'b1);
    fft_done = 1'b0;
    chk("overrun_clear", 32'(overrun), 32'd0);
    wait_idx(12);
    fft_done = 1'b1;
    tick(1'b1);
    tick(1'b1);
    chk("overrun_set", 32'(overrun), 32'd1);
    drain(0);
    repeat (3) begin
      tick(1'b1);
      chk("overrun_sticky", 32'({overrun, busy, m_valid}), 32'd4);
    end

    // Reset at bin 20 with fft_done held high
    fft_done = 1'b0;
    tick(1'b1);
    load_exp();
    fft_done = 1'b1;
    tick(1'b1);
    wait_idx(20);
    do_reset();
    chk("reset_mid", 32'({m_valid, m_data, m_index, m_last, busy, frame_done, overrun, rd_addr}), 32'd0);
    repeat (5) begin
      tick(1'b1);
      chk("reset_quiet", 32'({m_valid, busy, rd_addr}), 32'd0);
    end
    fft_done = 1'b0;
    tick(1'b1);
    load_exp();
    fft_done = 1'b1;
    tick(1'b1);
    fft_done = 1'b0;
    drain(0);

`ifdef FFT_OUT_FRAME_CNT_EN
    // 257 back-to-back frames wrap the counter to 1
    do_reset();
    tick(1'b1);
    for (int f = 0; f < 257; f++) begin
      load_exp();
      fft_done = 1'b1;
      tick(1'b1);
      fft_done = 1'b0;
      drain(0);
    end
    chk("frame_cnt_wrap", 32'(frame_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
